multi_cam_window_buffer: RTL

- Captures one rectangular window from each of NUM_CAMS AL422B frame FIFOs, one camera after another, into on-chip block RAM.
- Serves the stored pixels through a registered random-access read port, used by the VGA overlay and the disparity engine.
- Parametrised successor to the two-camera buffer: window position and size, channel count and data width are generic.
- Adds an explicit start/busy/done handshake, reset, and a bounds-checked read port.

---
 rtl/cam_buf_pkg.sv | 33 +++
 rtl/window_bram.sv | 35 +++
 rtl/multi_cam_window_buffer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cam_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_buf_pkg
// Description : Shared definitions for the multi-camera window buffer:
//               capture FSM state encoding, default FIFO frame geometry,
//               counter width and a constant-evaluable clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RRST  = 3'd1,
    ST_PRIME = 3'd2,
    ST_READ  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int DEF_LINE_PIXELS = 752;
  localparam int DEF_FRAME_LINES = 480;
  localparam int CNT_W           = 11;

  // Smallest r with 2**r >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/window_bram.sv
`default_nettype none
// ============================================================================
// Module      : window_bram
// Description : Simple dual-port RAM, one write port and one registered read
//               port, written so that synthesis maps it onto block RAM.
//               A same-cycle read and write of one address returns old data.
// Revision    : 1.0 - initial release
// Ports       : clk            - clock
//               we/waddr/wdata - write port
//               re/raddr       - read request and address
//               rdata          - registered read data (updates only when re)
// ============================================================================
module window_bram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2760,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/multi_cam_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : multi_cam_window_buffer
// Description : Reads one frame from each of NUM_CAMS AL422B FIFOs in turn,
//               stores a WIN_W x WIN_H window of each into block RAM and
//               serves it through a bounds-checked one-cycle read port.
// Revision    : 1.0 - initial release
// Ports       : fifo_rck     - FIFO read clock (sole clock)
//               rst_n        - asynchronous active-low reset
//               start        - one-cycle capture request
//               fifo_data    - FIFO outputs, camera k at [k*DATA_W +: DATA_W]
//               fifo_rrst    - per-camera read-pointer reset, active-low
//               fifo_rden    - per-camera read enable, active-low
//               busy         - capture in progress
//               frame_done   - one-cycle pulse when all cameras are stored
//               buffer_ready - buffers hold a complete capture
//               cur_cam      - camera currently being read
//               rd_en/rd_cam/rd_x/rd_y - read request
//               rd_data/rd_valid       - read response, one cycle later
// ============================================================================
module multi_cam_window_buffer
  import cam_buf_pkg::*;
#(
  parameter int NUM_CAMS    = 2,
  parameter int DATA_W      = 8,
  parameter int LINE_PIXELS = DEF_LINE_PIXELS,
  parameter int FRAME_LINES = DEF_FRAME_LINES,
  parameter int XMIN        = 329,
  parameter int YMIN        = 209,
  parameter int WIN_W       = 46,
  parameter int WIN_H       = 30
) (
  input  logic                       fifo_rck,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [NUM_CAMS*DATA_W-1:0] fifo_data,
  output logic [NUM_CAMS-1:0]        fifo_rrst,
  output logic [NUM_CAMS-1:0]        fifo_rden,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       buffer_ready,
  output logic [clog2(NUM_CAMS):0]   cur_cam,
  input  logic                       rd_en,
  input  logic [clog2(NUM_CAMS):0]   rd_cam,
  input  logic [CNT_W-1:0]           rd_x,
  input  logic [CNT_W-1:0]           rd_y,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid
);

  localparam int CAM_W  = clog2(NUM_CAMS) + 1;
  localparam int DEPTH  = NUM_CAMS * WIN_W * WIN_H;
  localparam int ADDR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

  localparam logic [ADDR_W-1:0] CAM_STRIDE = ADDR_W'(WIN_W * WIN_H);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(WIN_W);

  if (XMIN + WIN_W > LINE_PIXELS || YMIN + WIN_H > FRAME_LINES ||
      NUM_CAMS < 1 || NUM_CAMS > 4) begin : g_bad_geometry
    $error("multi_cam_window_buffer: window exceeds frame or NUM_CAMS out of range");
  end

  state_t             state, state_nx;
  logic [CNT_W-1:0]   pix_cnt, line_cnt;
  logic [CNT_W-1:0]   col, row;
  logic               in_win, last_win, last_cam;
  logic [NUM_CAMS-1:0] cam_sel;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr, rd_addr;
  logic [DATA_W-1:0]  ram_q;
  logic               rd_in_range, rd_hit;

  // Window-relative coordinates. Unsigned wrap makes a count below the
  // window origin land far above the window size, so one compare per axis
  // covers both bounds.
  assign col      = pix_cnt - CNT_W'(XMIN);
  assign row      = line_cnt - CNT_W'(YMIN);
  assign in_win   = (col < CNT_W'(WIN_W)) && (row < CNT_W'(WIN_H));
  assign last_win = (col == CNT_W'(WIN_W - 1)) && (row == CNT_W'(WIN_H - 1));
  assign last_cam = (cur_cam == CAM_W'(NUM_CAMS - 1));
  assign cam_sel  = NUM_CAMS'(1) << cur_cam;

  assign wr_en   = (state == ST_READ) && in_win;
  assign wr_addr = ADDR_W'(cur_cam) * CAM_STRIDE + ADDR_W'(row) * ROW_STRIDE + ADDR_W'(col);

  always_ff @(posedge fifo_rck or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cur_cam      <= '0;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      buffer_ready <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cur_cam      <= '0;
            buffer_ready <= 1'b0;
          end
        end
        ST_PRIME: begin
          pix_cnt  <= '0;
          line_cnt <= '0;
        end
        ST_READ: begin
          if (pix_cnt == CNT_W'(LINE_PIXELS - 1)) begin
            pix_cnt  <= '0;
            line_cnt <= line_cnt + CNT_W'(1);
          end else begin
            pix_cnt <= pix_cnt + CNT_W'(1);
          end
        end
        ST_NEXT: begin
          // Raised on the way into DONE so it is already high with frame_done.
          if (last_cam) buffer_ready <= 1'b1;
          else          cur_cam      <= cur_cam + CAM_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx   = state;
    fifo_rrst  = '1;
    fifo_rden  = '1;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_RRST;
      end
      ST_RRST: begin
        busy      = 1'b1;
        fifo_rrst = ~cam_sel;
        state_nx  = ST_PRIME;
      end
      ST_PRIME: begin
        // FIFO output lags the read enable by a cycle; this cycle is the fill.
        busy      = 1'b1;
        fifo_rden = ~cam_sel;
        state_nx  = ST_READ;
      end
      ST_READ: begin
        busy      = 1'b1;
        fifo_rden = ~cam_sel;
        if (last_win) state_nx = ST_NEXT;
      end
      ST_NEXT: begin
        busy     = 1'b1;
        state_nx = last_cam ? ST_DONE : ST_RRST;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_nx   = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Read port: out-of-range requests skip the RAM and return zero.
  assign rd_in_range = (rd_cam < CAM_W'(NUM_CAMS)) && (rd_x < CNT_W'(WIN_W)) &&
                       (rd_y < CNT_W'(WIN_H));
  assign rd_addr = ADDR_W'(rd_cam) * CAM_STRIDE + ADDR_W'(rd_y) * ROW_STRIDE + ADDR_W'(rd_x);

  always_ff @(posedge fifo_rck or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_hit <= rd_in_range;
    end
  end

  assign rd_data = rd_hit ? ram_q : '0;

  window_bram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk   (fifo_rck),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (fifo_data[cur_cam*DATA_W +: DATA_W]),
    .re    (rd_en && rd_in_range),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

endmodule
`default_nettype wire
